// File: rtl/fetch_queue_if.sv
// Fetch queue bus bundle: instruction memory request/response,
// redirect, and the instruction handshake toward decode.
interface fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr,
    output instr, instr_pc, instr_valid,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    input  instr, instr_pc, instr_valid,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding imem request, DEPTH-entry
// {pc, instr} FIFO, redirect flush. Optional FETCH_BYPASS_EN bypass.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic         clk,
  input logic         rst,
  fetch_queue_if.master bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q;
  logic [31:0]   fpc  [DEPTH];
  logic [31:0]   fins [DEPTH];
  logic [AW-1:0] rp_q, wp_q;
  logic [CW-1:0] cnt_q;

  logic empty, full;
  logic issue, resp, byp;
  logic valid, pop, push, fpop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

  assign issue = (state_q == IDLE) && !full
               && !bus.redirect && !rst;

  assign resp = (state_q == WAIT) && bus.imem_rvalid
              && !bus.redirect && !rst;

`ifdef FETCH_BYPASS_EN
  assign byp = resp && empty;
`else
  assign byp = 1'b0;
`endif

  assign valid = !rst && (!empty || byp);
  assign pop   = valid && bus.instr_ready
               && !bus.redirect;
  // A bypassed response consumed on the spot never enters the FIFO.
  assign push  = resp && !(byp && pop);
  assign fpop  = pop && !empty;

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid;

  always_comb begin
    bus.instr    = fins[rp_q];
    bus.instr_pc = fpc[rp_q];
    if (rst) begin
      bus.instr    = NOP;
      bus.instr_pc = 32'h0;
    end else if (byp) begin
      bus.instr    = bus.imem_rdata;
      bus.instr_pc = req_pc_q;
    end
  end

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      bus.redirect:
        pc_d = {bus.redirect_pc[31:2], 2'b00};
      issue && bus.imem_gnt:
        pc_d = pc_q + 32'd4;
      default: pc_d = pc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (issue && bus.imem_gnt)
          state_d = WAIT;
      end
      WAIT: begin
        if (bus.imem_rvalid)
          state_d = IDLE;
        else if (bus.redirect)
          state_d = DROP;
      end
      DROP: begin
        if (bus.imem_rvalid)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      rp_q     <= '0;
      wp_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (issue && bus.imem_gnt)
        req_pc_q <= pc_q;
      if (bus.redirect) begin
        rp_q  <= '0;
        wp_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push)
          wp_q <= wp_q + AW'(1);
        if (fpop)
          rp_q <= rp_q + AW'(1);
        cnt_q <= cnt_q + CW'(push) - CW'(fpop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fpc[wp_q]  <= req_pc_q;
      fins[wp_q] <= bus.imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, a DROP sequence,
// and randomized traffic against a queue-based reference model.
module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_if bus ();

  fetch_queue #(
    .RESET_PC(32'h0),
    .DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          r, g, v;
    logic [31:0] d;
    bit          rd;
    logic [31:0] rpc;
    bit          rdy;
    bit          er;
    logic [31:0] ea;
    bit          ev, evb;
    logic [31:0] ep, ei;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    bit r, bit g, bit v, logic [31:0] d,
    bit rd, logic [31:0] rpc, bit rdy,
    bit er, logic [31:0] ea, bit ev, bit evb,
    logic [31:0] ep, logic [31:0] ei);
    vec_t t;
    t.r = r; t.g = g; t.v = v; t.d = d;
    t.rd = rd; t.rpc = rpc; t.rdy = rdy;
    t.er = er; t.ea = ea; t.ev = ev; t.evb = evb;
    t.ep = ep; t.ei = ei;
    return t;
  endfunction

  function automatic logic [31:0] dat(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(bit r, bit g, bit v, logic [31:0] d,
                       bit rd, logic [31:0] rpc, bit rdy);
    @(negedge clk);
    rst             = r;
    bus.imem_gnt    = g;
    bus.imem_rvalid = v;
    bus.imem_rdata  = d;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.instr_ready = rdy;
    #1;
  endtask

  task automatic run_row(int i, vec_t t);
    bit ev;
    drive(t.r, t.g, t.v, t.d, t.rd, t.rpc, t.rdy);
    ev = BYP ? t.evb : t.ev;
    chk($sformatf("row%0d req", i), 32'(bus.imem_req), 32'(t.er));
    if (t.er)
      chk($sformatf("row%0d addr", i), bus.imem_addr, t.ea);
    chk($sformatf("row%0d valid", i), 32'(bus.instr_valid), 32'(ev));
    if (ev || t.r) begin
      chk($sformatf("row%0d pc", i), bus.instr_pc, t.ep);
      chk($sformatf("row%0d instr", i), bus.instr, t.ei);
    end
  endtask

  // reference model state
  logic [31:0] mq_pc[$];
  logic [31:0] mq_in[$];
  logic [31:0] mpc, mout_pc, cur_pc;
  bit          mout, mstale;
  bit          mpend;
  int          mlat;
  logic [31:0] maddr;

  initial begin
    bit r, g, v, rd, rdy, ereq, eb, ev, pop;
    logic [31:0] d, rpc;

    rst = 1'b1;
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
    bus.redirect = 0; bus.redirect_pc = 0; bus.instr_ready = 0;

    // r g v rdata rd rpc rdy | req addr v vb pc instr
    tbl.push_back(mk(1,1,1,32'h0,0,0,1, 0,0,0,0,0,NOP));
    tbl.push_back(mk(0,1,1,32'hDEAD0001,0,0,1, 1,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,32'hA0000000,0,0,1, 0,0,0,1,0,32'hA0000000));
    tbl.push_back(mk(0,1,1,32'hDEAD0002,0,0,1, 1,4,1,0,0,32'hA0000000));
    tbl.push_back(mk(0,1,1,32'hA0000004,0,0,1, 0,0,0,1,4,32'hA0000004));
    tbl.push_back(mk(0,1,1,32'hDEAD0003,0,0,1, 1,8,1,0,4,32'hA0000004));
    tbl.push_back(mk(1,0,1,32'h0,0,0,0, 0,0,0,0,0,NOP));
    tbl.push_back(mk(0,1,0,32'h0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,32'hA0000000,0,0,0, 0,0,0,1,0,32'hA0000000));
    tbl.push_back(mk(0,1,0,32'h0,0,0,0, 1,4,1,1,0,32'hA0000000));
    tbl.push_back(mk(0,1,1,32'hA0000004,0,0,0, 0,0,1,1,0,32'hA0000000));
    tbl.push_back(mk(0,1,0,32'h0,0,0,0, 0,0,1,1,0,32'hA0000000));
    tbl.push_back(mk(0,1,0,32'h0,0,0,0, 0,0,1,1,0,32'hA0000000));
    tbl.push_back(mk(0,1,0,32'h0,0,0,1, 0,0,1,1,0,32'hA0000000));
    tbl.push_back(mk(0,1,0,32'h0,0,0,1, 1,8,1,1,4,32'hA0000004));
    tbl.push_back(mk(0,0,0,32'h0,1,32'h100,1, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,32'hA0000008,0,0,1, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,32'hDEAD0004,0,0,1, 1,32'h100,0,0,0,0));
    tbl.push_back(mk(0,0,1,32'hA0000100,0,0,0, 0,0,0,1,32'h100,32'hA0000100));
    tbl.push_back(mk(0,1,0,32'h0,0,0,0, 1,32'h104,1,1,32'h100,32'hA0000100));
    tbl.push_back(mk(0,0,1,32'hA0000104,1,32'h203,1, 0,0,1,1,32'h100,32'hA0000100));
    tbl.push_back(mk(0,0,0,32'h0,0,0,1, 1,32'h200,0,0,0,0));
    tbl.push_back(mk(0,1,0,32'h0,1,32'hFFFFFFFE,1, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,32'h0,0,0,1, 1,32'hFFFFFFFC,0,0,0,0));
    tbl.push_back(mk(0,1,1,32'h55,0,0,1, 0,0,0,1,32'hFFFFFFFC,32'h55));
    tbl.push_back(mk(0,1,0,32'h0,0,0,1, 1,0,1,0,32'hFFFFFFFC,32'h55));
    tbl.push_back(mk(1,0,0,32'h0,0,0,1, 0,0,0,0,0,NOP));
    tbl.push_back(mk(0,0,1,32'h77,0,0,1, 1,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,32'h0,0,0,1, 1,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,32'h99,0,0,1, 0,0,0,1,0,32'h99));
    tbl.push_back(mk(0,0,0,32'h0,0,0,1, 1,4,1,0,0,32'h99));

    foreach (tbl[i]) run_row(i, tbl[i]);

    // second redirect while dropping a stale response
    drive(1,0,0,0,0,0,1);
    drive(0,1,0,0,0,0,1);
    chk("drop issue", 32'(bus.imem_req), 32'd1);
    drive(0,0,0,0,1,32'h300,1);
    chk("drop rd1 req", 32'(bus.imem_req), 32'd0);
    drive(0,1,0,0,1,32'h400,1);
    chk("drop rd2 req", 32'(bus.imem_req), 32'd0);
    drive(0,1,1,32'hBAD,0,0,1);
    chk("drop stale req", 32'(bus.imem_req), 32'd0);
    chk("drop stale valid", 32'(bus.instr_valid), 32'd0);
    drive(0,0,0,0,0,0,1);
    chk("drop resume req", 32'(bus.imem_req), 32'd1);
    chk("drop resume addr", bus.imem_addr, 32'h400);
    chk("drop resume valid", 32'(bus.instr_valid), 32'd0);

    // randomized traffic against the reference model
    mpend = 0; mlat = 0; maddr = 0;
    mout = 0; mstale = 0; mpc = 0; mout_pc = 0;
    for (int i = 0; i < 3000; i++) begin
      r   = (i == 0) || ($urandom_range(0, 79) == 0);
      rd  = ($urandom_range(0, 11) == 0);
      rpc = $urandom;
      rdy = ($urandom_range(0, 9) < 7);
      g   = !mpend && ($urandom_range(0, 9) < 7);
      v   = mpend && (mlat == 0);
      d   = v ? dat(maddr) : $urandom;
      drive(r, g, v, d, rd, rpc, rdy);

      cur_pc = mpc;
      ereq = !r && !mout && (mq_pc.size() < 2) && !rd;
      eb   = BYP && !r && !rd && mout && !mstale && v
             && (mq_pc.size() == 0);
      ev   = !r && ((mq_pc.size() > 0) || eb);
      chk($sformatf("rnd%0d req", i), 32'(bus.imem_req), 32'(ereq));
      if (ereq)
        chk($sformatf("rnd%0d addr", i), bus.imem_addr, mpc);
      chk($sformatf("rnd%0d valid", i), 32'(bus.instr_valid), 32'(ev));
      if (r) begin
        chk($sformatf("rnd%0d rpc", i), bus.instr_pc, 32'h0);
        chk($sformatf("rnd%0d rins", i), bus.instr, NOP);
      end else if (ev) begin
        chk($sformatf("rnd%0d pc", i), bus.instr_pc,
            eb ? mout_pc : mq_pc[0]);
        chk($sformatf("rnd%0d instr", i), bus.instr,
            eb ? d : mq_in[0]);
      end

      if (r) begin
        mq_pc.delete(); mq_in.delete();
        mpc = 0; mout = 0; mstale = 0;
      end else if (rd) begin
        mq_pc.delete(); mq_in.delete();
        mpc = rpc & ~32'h3;
        if (mout && v) begin
          mout = 0; mstale = 0;
        end else if (mout) begin
          mstale = 1;
        end
      end else begin
        pop = ev && rdy;
        if (pop && !eb) begin
          void'(mq_pc.pop_front());
          void'(mq_in.pop_front());
        end
        if (mout && v) begin
          if (!mstale && !(eb && pop)) begin
            mq_pc.push_back(mout_pc);
            mq_in.push_back(d);
          end
          mout = 0; mstale = 0;
        end
        if (ereq && g) begin
          mout = 1; mstale = 0;
          mout_pc = mpc;
          mpc = mpc + 32'd4;
        end
      end

      if (v) mpend = 0;
      else if (mpend && mlat > 0) mlat--;
      if (ereq && g) begin
        mpend = 1;
        mlat  = $urandom_range(0, 2);
        maddr = cur_pc;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
